// File: rtl/mmio_fifo_pkg.sv
// Shared constants and types for the MMIO FIFO register block.
// Register offsets, STATUS bit positions and the STATUS layout struct.
package mmio_fifo_pkg;

  localparam logic [15:0] OFF_DATA   = 16'd0;
  localparam logic [15:0] OFF_STATUS = 16'd2;
  localparam logic [15:0] OFF_CTRL   = 16'd4;
  localparam logic [15:0] OFF_THRESH = 16'd6;

  localparam int ST_EMPTY   = 16;
  localparam int ST_FULL    = 17;
  localparam int ST_OVF     = 18;
  localparam int ST_UDF     = 19;
  localparam int ST_ILLEGAL = 20;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  typedef struct packed {
    logic [10:0] rsvd;
    logic        illegal;
    logic        udf;
    logic        ovf;
    logic        full;
    logic        empty;
    logic [15:0] count;
  } t_fifo_status;

endpackage

// File: rtl/mmio_fifo_regs_buf.sv
// Circular buffer: memory, wrapping pointers, count, full/empty.
// Ports: clk, rst_n, push/pop/flush, push_data in; pop_data (registered), count, full, empty out.
module fifo_circ_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      push_data,
  output logic [DATA_W-1:0]      pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // A pop from empty returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_data <= '0;
    end else if (pop) begin
      pop_data <= empty ? '0 : mem[rd_ptr];
    end
  end

endmodule

// File: rtl/mmio_fifo_regs.sv
// MMIO-mapped FIFO: address decode, sticky flags, THRESH and 1-cycle read response.
// Ports: clk, rst_n, mmio_{wr,rd}_valid/addr/tid/wdata in; rsp_{valid,tid,data}, hit, thresh_irq out.
module mmio_fifo_regs
  import mmio_fifo_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          DEPTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wdata,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        hit,
  output logic        thresh_irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]       off;
  logic              is_data;
  logic              is_status;
  logic              is_ctrl;
  logic              is_thresh;
  logic              wr_ok;
  logic              rd_ok;
  logic              push;
  logic              pop;
  logic              flush;
  logic              clr;
  logic              set_ovf;
  logic              set_udf;
  logic              set_ill;
  logic              ovf;
  logic              udf;
  logic              illegal;
  logic [15:0]       thresh;
  logic [DATA_W-1:0] pop_data;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  t_fifo_status      st;
  logic [63:0]       rd_mux;
  logic [63:0]       rsp_reg;
  logic              rsp_sel_buf;

  assign off       = mmio_addr - BASE_ADDR;
  assign hit       = (mmio_addr >= BASE_ADDR) && (off <= OFF_THRESH);
  assign is_data   = (off == OFF_DATA);
  assign is_status = (off == OFF_STATUS);
  assign is_ctrl   = (off == OFF_CTRL);
  assign is_thresh = (off == OFF_THRESH);

  // A read wins over a same-cycle write.
  assign wr_ok = mmio_wr_valid && !mmio_rd_valid && hit;
  assign rd_ok = mmio_rd_valid && hit;

  assign push  = wr_ok && is_data;
  assign pop   = rd_ok && is_data;
  assign flush = wr_ok && is_ctrl && mmio_wdata[CTRL_FLUSH];
  assign clr   = wr_ok && is_ctrl && mmio_wdata[CTRL_CLR];

  assign set_ovf = push && full;
  assign set_udf = pop && empty;
  assign set_ill = mmio_wr_valid && mmio_rd_valid && hit;

  fifo_circ_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (mmio_wdata[DATA_W-1:0]),
    .pop_data  (pop_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf     <= 1'b0;
      udf     <= 1'b0;
      illegal <= 1'b0;
    end else begin
      ovf     <= set_ovf | (ovf & ~clr);
      udf     <= set_udf | (udf & ~clr);
      illegal <= set_ill | (illegal & ~clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh <= 16'(DEPTH - 1);
    end else if (wr_ok && is_thresh) begin
      thresh <= (mmio_wdata[15:0] > 16'(DEPTH)) ?
                16'(DEPTH) : mmio_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_irq <= 1'b0;
    end else begin
      thresh_irq <= (16'(count) >= thresh) && (thresh != '0);
    end
  end

  always_comb begin
    st         = '0;
    st.count   = 16'(count);
    st.empty   = empty;
    st.full    = full;
    st.ovf     = ovf;
    st.udf     = udf;
    st.illegal = illegal;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      is_status: rd_mux = {32'd0, st};
      is_thresh: rd_mux = {48'd0, thresh};
      default:   rd_mux = '0;
    endcase
  end

  // DATA pops come from the buffer's own output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_tid     <= '0;
      rsp_reg     <= '0;
      rsp_sel_buf <= 1'b0;
    end else begin
      rsp_valid <= rd_ok;
      if (rd_ok) begin
        rsp_tid     <= mmio_tid;
        rsp_reg     <= rd_mux;
        rsp_sel_buf <= is_data;
      end
    end
  end

  assign rsp_data = rsp_sel_buf ? 64'(pop_data) : rsp_reg;

endmodule

// File: tb/tb_mmio_fifo_regs.sv
// Self-checking bench for mmio_fifo_regs (64-bit and 8-bit instances).
// Queue-based reference model, directed steps plus random traffic.
module tb_mmio_fifo_regs;
  import mmio_fifo_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [15:0] BASE  = 16'h0020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;

  logic        rsp_valid0, rsp_valid1;
  logic [8:0]  rsp_tid0, rsp_tid1;
  logic [63:0] rsp_data0, rsp_data1;
  logic        hit0, hit1;
  logic        irq0, irq1;

  always #5 clk = ~clk;

  mmio_fifo_regs #(.DATA_W(64), .DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .rsp_valid(rsp_valid0), .rsp_tid(rsp_tid0), .rsp_data(rsp_data0),
    .hit(hit0), .thresh_irq(irq0)
  );

  mmio_fifo_regs #(.DATA_W(8), .DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .rsp_valid(rsp_valid1), .rsp_tid(rsp_tid1), .rsp_data(rsp_data1),
    .hit(hit1), .thresh_irq(irq1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: q holds full 64-bit pushed words.
  logic [63:0] q[$];
  bit          m_ovf, m_udf, m_ill;
  int          m_th;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_irq();
    return (m_th != 0) && (q.size() >= m_th);
  endfunction

  function automatic logic [63:0] m_status();
    logic [63:0] s;
    s = 64'(q.size());
    s[ST_EMPTY]   = (q.size() == 0);
    s[ST_FULL]    = (q.size() == DEPTH);
    s[ST_OVF]     = m_ovf;
    s[ST_UDF]     = m_udf;
    s[ST_ILLEGAL] = m_ill;
    return s;
  endfunction

  function automatic void m_reset();
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_ill = 0;
    m_th  = DEPTH - 1;
  endfunction

  task automatic op(bit w, bit r, logic [15:0] addr, logic [63:0] wd);
    bit          h;
    bit          exp_v;
    bit          exp_irq;
    int          off;
    logic [8:0]  tid;
    logic [63:0] exp_d0;
    logic [63:0] exp_d1;
    tid = 9'($urandom_range(0, 511));
    @(negedge clk);
    mmio_wr_valid = w;
    mmio_rd_valid = r;
    mmio_addr     = addr;
    mmio_tid      = tid;
    mmio_wdata    = wd;
    h = (addr >= BASE) && (addr <= BASE + 16'd6);
    #1;
    chk("hit", {hit1, hit0}, {h, h});
    exp_irq = m_irq();
    off     = int'(addr) - int'(BASE);
    exp_v   = r && h;
    exp_d0  = '0;
    exp_d1  = '0;
    if (r && h) begin
      case (off)
        0: begin
          if (q.size() == 0) m_udf = 1;
          else exp_d0 = q.pop_front();
          exp_d1 = exp_d0 & 64'hFF;
        end
        2: begin exp_d0 = m_status(); exp_d1 = exp_d0; end
        6: begin exp_d0 = 64'(m_th); exp_d1 = exp_d0; end
        default: ;
      endcase
    end
    if (w && r && h) begin
      m_ill = 1;
    end else if (w && h) begin
      case (off)
        0: if (q.size() == DEPTH) m_ovf = 1; else q.push_back(wd);
        4: begin
          if (wd[0]) q.delete();
          if (wd[1]) begin m_ovf = 0; m_udf = 0; m_ill = 0; end
        end
        6: m_th = (wd[15:0] > DEPTH) ? DEPTH : int'(wd[15:0]);
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    chk("rsp_valid", {rsp_valid1, rsp_valid0}, {exp_v, exp_v});
    if (exp_v) begin
      chk("rsp_tid64", rsp_tid0, tid);
      chk("rsp_tid8", rsp_tid1, tid);
      chk("rsp_data64", rsp_data0, exp_d0);
      chk("rsp_data8", rsp_data1, exp_d1);
    end
    chk("thresh_irq", {irq1, irq0}, {exp_irq, exp_irq});
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    chk("idle_valid", {rsp_valid1, rsp_valid0}, 2'b00);
    chk("idle_irq", {irq1, irq0}, {m_irq(), m_irq()});
  endtask

  initial begin
    logic [15:0] a;
    logic [63:0] d;
    mmio_wr_valid = 0;
    mmio_rd_valid = 0;
    mmio_addr     = 0;
    mmio_tid      = 0;
    mmio_wdata    = 0;
    rst_n         = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {rsp_valid1, rsp_valid0}, 2'b00);
    chk("reset_data", rsp_data0 | rsp_data1, 64'd0);
    chk("reset_irq", {irq1, irq0}, 2'b00);
    @(negedge clk);
    rst_n = 1;

    op(0, 1, BASE + 2, 0);
    chk("status_after_reset", rsp_data0, 64'h0001_0000);
    op(0, 1, BASE + 6, 0);
    chk("thresh_after_reset", rsp_data0, 64'd15);

    for (int i = 0; i < 16; i++) op(1, 0, BASE, 64'hA0 + 64'(i));
    op(0, 1, BASE + 2, 0);
    chk("status_full", rsp_data0, 64'h0002_0010);
    op(1, 0, BASE, 64'hFF);
    op(0, 1, BASE + 2, 0);
    chk("status_ovf", rsp_data0, 64'h0006_0010);

    for (int i = 0; i < 16; i++) op(0, 1, BASE, 0);
    op(0, 1, BASE, 0);
    chk("underflow_data", rsp_data0, 64'd0);
    idle();
    op(0, 1, BASE + 2, 0);
    chk("status_udf", rsp_data0, 64'h000D_0000);

    op(1, 0, BASE + 4, 64'h2);
    for (int i = 0; i < 10; i++) op(1, 0, BASE, {$urandom, $urandom});
    for (int i = 0; i < 10; i++) op(0, 1, BASE, 0);
    for (int i = 0; i < 16; i++) op(1, 0, BASE, {$urandom, $urandom});
    for (int i = 0; i < 16; i++) op(0, 1, BASE, 0);
    op(0, 1, BASE + 2, 0);
    chk("status_wrap", rsp_data0, 64'h0001_0000);

    op(1, 0, BASE, 64'h1234);
    op(0, 1, BASE, 0);
    chk("narrow_pop", rsp_data1, 64'h34);

    op(1, 0, BASE + 6, 64'd4);
    for (int i = 0; i < 4; i++) op(1, 0, BASE, 64'h50 + 64'(i));
    idle();
    chk("irq_at_thresh", {irq1, irq0}, 2'b11);
    op(1, 0, BASE + 4, 64'h3);
    idle();
    chk("irq_after_flush", {irq1, irq0}, 2'b00);
    op(0, 1, BASE + 2, 0);
    chk("status_flushed", rsp_data0, 64'h0001_0000);

    op(1, 0, BASE + 6, 64'd100);
    op(0, 1, BASE + 6, 0);
    chk("thresh_clamp", rsp_data0, 64'd16);

    op(1, 0, BASE, 64'h77);
    op(1, 1, BASE, 64'h88);
    op(0, 1, BASE + 2, 0);
    chk("status_illegal", rsp_data0, 64'h0011_0000);

    op(1, 1, BASE + 7, 64'h1);
    op(0, 1, BASE - 1, 0);
    op(0, 1, BASE + 4, 0);
    op(0, 1, BASE + 3, 0);
    op(1, 0, BASE + 4, 64'h2);

    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 1) == 0) ?
          BASE : BASE - 16'd1 + 16'($urandom_range(0, 8));
      d = {$urandom, $urandom};
      if (a == BASE + 4 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      if (a == BASE + 6 && $urandom_range(0, 3) != 0)
        d = 64'($urandom_range(0, 20));
      case ($urandom_range(0, 9))
        0:          op(1, 1, a, d);
        1, 2, 3, 4: op(1, 0, a, d);
        5:          idle();
        default:    op(0, 1, a, d);
      endcase
    end

    for (int i = 0; i < 3; i++) op(1, 0, BASE, 64'hC0 + 64'(i));
    @(negedge clk);
    mmio_rd_valid = 1;
    mmio_addr     = BASE;
    mmio_tid      = 9'h1AB;
    @(posedge clk);
    #1;
    mmio_rd_valid = 0;
    chk("pre_reset_valid", {rsp_valid1, rsp_valid0}, 2'b11);
    rst_n = 0;
    #1;
    m_reset();
    chk("mid_reset_valid", {rsp_valid1, rsp_valid0}, 2'b00);
    chk("mid_reset_data", rsp_data0 | rsp_data1, 64'd0);
    chk("mid_reset_tid", {rsp_tid1, rsp_tid0}, 18'd0);
    @(negedge clk);
    rst_n = 1;
    op(0, 1, BASE + 2, 0);
    chk("status_post_reset", rsp_data0, 64'h0001_0000);
    op(0, 1, BASE, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_regs.md
Name: mmio_fifo_regs

Overview:
Parametrised MMIO-mapped FIFO for the AFU user-register space. It replaces the fixed 64-bit single-register/shift-FIFO arrangement with a circular buffer of configurable width and depth. The buffer has status, control and threshold registers. The host pushes by MMIO-writing the DATA register and pops by MMIO-reading it. The block sits behind the AFU's MMIO decode and returns read responses with 1-cycle latency, as CCI-P requires.

Parameters:
DATA_W, 64, FIFO entry width in bits (1..64); read data zero-extended to 64.
DEPTH, 16, entry count; power of two, 2..1024.
BASE_ADDR, 16'h0020, DWORD address of DATA register; other registers at fixed offsets.

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous, active-low
mmio_wr_valid  in  1  MMIO write strobe (from rx.c0.mmioWrValid)
mmio_rd_valid  in  1  MMIO read strobe (from rx.c0.mmioRdValid)
mmio_addr  in  16  MMIO DWORD address (mmio_hdr.address)
mmio_tid  in  9  request TID
mmio_wdata  in  64  write data (rx.c0.data[63:0])
rsp_valid  out  1  read response valid (to tx.c2.mmioRdValid)
rsp_tid  out  9  echoed TID
rsp_data  out  64  read response data
hit  out  1  combinational: mmio_addr within BASE_ADDR..BASE_ADDR+6
thresh_irq  out  1  registered: count >= THRESH and THRESH != 0

Behaviour:
- Reset (rst_n low, async): wr_ptr, rd_ptr, count, ovf, udf, illegal set to 0; THRESH set to DEPTH-1; rsp_valid, rsp_tid, rsp_data, thresh_irq set to 0. Buffer contents are not reset. Reset mid-operation discards all entries and any pending response.
- Register map (DWORD offsets from BASE_ADDR):
  - +0 DATA: write pushes mmio_wdata[DATA_W-1:0]; read pops.
  - +2 STATUS (RO): [15:0] count, [16] empty, [17] full, [18] ovf, [19] udf, [20] illegal, rest 0.
  - +4 CTRL (WO, reads 0): bit0 flushes (ptrs and count to 0); bit1 clears ovf/udf/illegal. Both bits may be set together.
  - +6 THRESH (RW): [15:0], write clamped to DEPTH.
- Read latency: exactly 1 cycle. A read accepted in cycle N gives rsp_valid=1 in N+1 for one cycle, with rsp_tid = mmio_tid from cycle N.
- Only hit reads produce a response. Non-hit strobes are ignored entirely; the AFU top muxes them.
- Push to full: data dropped, pointers unchanged, ovf set (sticky).
- Pop from empty: rsp_data=0, pointers unchanged, udf set (sticky).
- Pop: rsp_data = entry at rd_ptr, zero-extended; rd_ptr advances; count decrements.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits. Full means count==DEPTH.
- mmio_wr_valid and mmio_rd_valid in the same cycle: the read is serviced and the write is dropped. If either targeted the block, illegal is set.
- CTRL flush in the same cycle as a pending response: the response, already registered, still completes.
- thresh_irq updates one cycle after count or THRESH changes.
- Sticky-flag clear and a new error in the same cycle: the set wins.

Decomposition:
- Package mmio_fifo_pkg holds register offset constants (OFF_DATA=0, OFF_STATUS=2, OFF_CTRL=4, OFF_THRESH=6), STATUS bit-position constants, and a packed struct t_fifo_status.
- Sub-module fifo_circ_buf(DATA_W, DEPTH) holds the memory, pointers, count, full and empty, with push/pop inputs and a registered pop output. mmio_fifo_regs holds the decode, flags, THRESH and response logic.

Test Plan:
- Reset, then read STATUS -> rsp_data=0x0001_0000 (empty=1, count=0); read THRESH -> 15.
- Push 0xA0..0xAF (16 writes), then read STATUS -> count=16, full=1; push 0xFF -> ovf=1, count stays 16.
- 16 pops after the fill -> rsp_data 0xA0..0xAF in order, each 1 cycle after the strobe with the matching TID; a 17th pop -> rsp_data=0, udf=1.
- Wrap test: push 10, pop 10, push 16, pop 16 -> all data in order, no ovf/udf.
- DATA_W=8: push 0x1234 -> pop returns 0x34; THRESH=4 after 4 pushes -> thresh_irq=1 on the cycle after the 4th push; write CTRL=3 -> count=0, flags cleared, irq deasserts next cycle.
- Simultaneous rd+wr to DATA -> read serviced, write dropped, illegal=1; assert rst_n low mid-response -> rsp_valid=0 immediately.
